pl_hazard_fwd: RTL and testbench

Parametrised hazard-detection and forwarding unit for the in-order pipelined RISC-V core. It generalises the fixed EX/MEM/WB load-use stall and 2-source forwarding to NSTAGE post-decode slots with per-instruction result latency. It keeps its own shift register of in-flight destination records, stalls the IF/ID stage when a source is not yet forwardable, and drives the EX operand muxes. It sits beside the ID/EX datapath and also keeps saturating stall and flush counters.

---
 rtl/pl_hazard_fwd_if.sv | 41 ++++
 rtl/pl_hazard_fwd.sv | 123 ++++++++++++
 tb/tb_pl_hazard_fwd.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pl_hazard_fwd_if.sv
// rtl/pl_hazard_fwd_if.sv - ID/EX-side signal bundle of the hazard detection and forwarding unit
interface pl_hazard_fwd_if #(
  parameter int XLEN   = 32,
  parameter int NSTAGE = 3,
  parameter int LATW   = 2,
  parameter int CNTW   = 16,
  parameter int SELW   = $clog2(NSTAGE)
);
  logic                   id_valid;
  logic [4:0]             id_rs1;
  logic [4:0]             id_rs2;
  logic                   id_use_rs1;
  logic                   id_use_rs2;
  logic [4:0]             id_rd;
  logic                   id_wen;
  logic [LATW-1:0]        id_lat;
  logic                   flush;
  logic [XLEN-1:0]        ex_rd1;
  logic [XLEN-1:0]        ex_rd2;
  logic [NSTAGE*XLEN-1:0] stage_res;
  logic                   stall;
  logic [XLEN-1:0]        ex_op_a;
  logic [XLEN-1:0]        ex_op_b;
  logic [SELW-1:0]        fwd_a_sel;
  logic [SELW-1:0]        fwd_b_sel;
  logic [NSTAGE-1:0]      slot_valid;
  logic [CNTW-1:0]        stall_cnt;
  logic [CNTW-1:0]        flush_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_wen, id_lat,
    output flush, ex_rd1, ex_rd2, stage_res,
    input  stall, ex_op_a, ex_op_b, fwd_a_sel, fwd_b_sel, slot_valid, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_wen, id_lat,
    input  flush, ex_rd1, ex_rd2, stage_res,
    output stall, ex_op_a, ex_op_b, fwd_a_sel, fwd_b_sel, slot_valid, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pl_hazard_fwd.sv
// rtl/pl_hazard_fwd.sv - NSTAGE-slot hazard detection, load-use stall and EX operand forwarding
module pl_hazard_fwd #(
  parameter int XLEN   = 32,
  parameter int NSTAGE = 3,
  parameter int LATW   = 2,
  parameter int CNTW   = 16,
  parameter int SELW   = $clog2(NSTAGE)
) (
  input  logic           clk,
  input  logic           rst_n,
  pl_hazard_fwd_if.slave bus
);

  logic [NSTAGE-1:0] valid_q, valid_d;
  logic [NSTAGE-1:0] wen_q, wen_d;
  logic [4:0]        rd_q  [NSTAGE];
  logic [4:0]        rd_d  [NSTAGE];
  logic [LATW-1:0]   lat_q [NSTAGE];
  logic [LATW-1:0]   lat_d [NSTAGE];
  logic [4:0]        rs1_q, rs1_d, rs2_q, rs2_d;
  logic              use1_q, use1_d, use2_q, use2_d;
  logic [CNTW-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNTW-1:0]   flush_cnt_q, flush_cnt_d;

  logic              wait_a, wait_b, stall, take;
  logic [SELW-1:0]   sel_a, sel_b;
  logic [XLEN-1:0]   op_a, op_b;

  // Scan oldest to youngest so the nearest producer overwrites any older one.
  always_comb begin : detect
    wait_a = 1'b0;
    wait_b = 1'b0;
    for (int j = NSTAGE - 1; j >= 0; j--) begin
      if (valid_q[j] && wen_q[j] && bus.id_use_rs1 && bus.id_rs1 != 5'd0 && rd_q[j] == bus.id_rs1)
        wait_a = int'(lat_q[j]) > j;
      if (valid_q[j] && wen_q[j] && bus.id_use_rs2 && bus.id_rs2 != 5'd0 && rd_q[j] == bus.id_rs2)
        wait_b = int'(lat_q[j]) > j;
    end
    stall = bus.id_valid && !bus.flush && (wait_a || wait_b);
    take  = bus.id_valid && !bus.flush && !stall;
  end

  always_comb begin : forward
    sel_a = '0;
    sel_b = '0;
    op_a  = bus.ex_rd1;
    op_b  = bus.ex_rd2;
    for (int k = NSTAGE - 1; k >= 1; k--) begin
      if (valid_q[0] && use1_q && rs1_q != 5'd0 && valid_q[k] && wen_q[k] && rd_q[k] == rs1_q) begin
        sel_a = SELW'(k);
        op_a  = bus.stage_res[k*XLEN +: XLEN];
      end
      if (valid_q[0] && use2_q && rs2_q != 5'd0 && valid_q[k] && wen_q[k] && rd_q[k] == rs2_q) begin
        sel_b = SELW'(k);
        op_b  = bus.stage_res[k*XLEN +: XLEN];
      end
    end
  end

  // Bubbles clear every field so a stale source can never trigger a forward.
  always_comb begin : next_state
    valid_d[0] = take;
    wen_d[0]   = take && bus.id_wen;
    rd_d[0]    = take ? bus.id_rd  : 5'd0;
    lat_d[0]   = take ? bus.id_lat : '0;
    rs1_d      = take ? bus.id_rs1 : 5'd0;
    rs2_d      = take ? bus.id_rs2 : 5'd0;
    use1_d     = take && bus.id_use_rs1;
    use2_d     = take && bus.id_use_rs2;
    for (int k = 1; k < NSTAGE; k++) begin
      valid_d[k] = valid_q[k-1];
      wen_d[k]   = wen_q[k-1];
      rd_d[k]    = rd_q[k-1];
      lat_d[k]   = lat_q[k-1];
    end
    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + CNTW'(1);
    flush_cnt_d = flush_cnt_q;
    if (bus.flush && bus.id_valid && flush_cnt_q != '1)
      flush_cnt_d = flush_cnt_q + CNTW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= '0;
      wen_q       <= '0;
      for (int k = 0; k < NSTAGE; k++) begin
        rd_q[k]  <= 5'd0;
        lat_q[k] <= '0;
      end
      rs1_q       <= 5'd0;
      rs2_q       <= 5'd0;
      use1_q      <= 1'b0;
      use2_q      <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      wen_q       <= wen_d;
      for (int k = 0; k < NSTAGE; k++) begin
        rd_q[k]  <= rd_d[k];
        lat_q[k] <= lat_d[k];
      end
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      use1_q      <= use1_d;
      use2_q      <= use2_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall      = stall;
  assign bus.ex_op_a    = op_a;
  assign bus.ex_op_b    = op_b;
  assign bus.fwd_a_sel  = sel_a;
  assign bus.fwd_b_sel  = sel_b;
  assign bus.slot_valid = valid_q;
  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_pl_hazard_fwd.sv
// tb/tb_pl_hazard_fwd.sv - bench for pl_hazard_fwd (16-bit and 4-bit counter instances on shared stimulus)
module tb_pl_hazard_fwd;
  localparam int XLEN = 32;
  localparam int NS   = 3;

  logic clk;
  logic rst_n;

  pl_hazard_fwd_if #(.XLEN(XLEN), .NSTAGE(NS), .CNTW(16)) bus ();
  pl_hazard_fwd_if #(.XLEN(XLEN), .NSTAGE(NS), .CNTW(4))  bus4 ();

  pl_hazard_fwd #(.XLEN(XLEN), .NSTAGE(NS), .CNTW(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );
  pl_hazard_fwd #(.XLEN(XLEN), .NSTAGE(NS), .CNTW(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4.slave)
  );

  assign bus4.id_valid   = bus.id_valid;
  assign bus4.id_rs1     = bus.id_rs1;
  assign bus4.id_rs2     = bus.id_rs2;
  assign bus4.id_use_rs1 = bus.id_use_rs1;
  assign bus4.id_use_rs2 = bus.id_use_rs2;
  assign bus4.id_rd      = bus.id_rd;
  assign bus4.id_wen     = bus.id_wen;
  assign bus4.id_lat     = bus.id_lat;
  assign bus4.flush      = bus.flush;
  assign bus4.ex_rd1     = bus.ex_rd1;
  assign bus4.ex_rd2     = bus.ex_rd2;
  assign bus4.stage_res  = bus.stage_res;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: instructions in flight indexed by age (0 = just entered EX).
  typedef struct {
    bit       v;
    bit       wen;
    bit [4:0] rd;
    int       lat;
    bit [4:0] rs1;
    bit [4:0] rs2;
    bit       u1;
    bit       u2;
  } rec_t;

  rec_t m [NS];
  int   scnt, fcnt;
  bit   exp_stall;
  int   n_assert, n_fail;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_assert++;
    assert (obs === want)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  function automatic bit must_wait(input bit [4:0] r, input bit u);
    bit done = 1'b0;
    bit res  = 1'b0;
    if (u && r != 5'd0)
      for (int j = 0; j < NS; j++)
        if (!done && m[j].v && m[j].wen && m[j].rd == r) begin
          done = 1'b1;
          res  = (j < m[j].lat);
        end
    return res;
  endfunction

  function automatic int fwd_src(input bit [4:0] r, input bit u);
    int src = 0;
    if (m[0].v && u && r != 5'd0)
      for (int k = 1; k < NS; k++)
        if (src == 0 && m[k].v && m[k].wen && m[k].rd == r) src = k;
    return src;
  endfunction

  function automatic int sat4(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NS; k++) m[k] = '{default: 0};
    scnt = 0;
    fcnt = 0;
  endtask

  task automatic set_id(input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
                        input int rd, input bit wen, input int lat);
    bus.id_valid   = v;
    bus.id_rs1     = 5'(rs1);
    bus.id_rs2     = 5'(rs2);
    bus.id_use_rs1 = u1;
    bus.id_use_rs2 = u2;
    bus.id_rd      = 5'(rd);
    bus.id_wen     = wen;
    bus.id_lat     = 2'(lat);
  endtask

  task automatic rnd_data();
    bus.ex_rd1 = $urandom;
    bus.ex_rd2 = $urandom;
    for (int k = 0; k < NS; k++) bus.stage_res[k*XLEN +: XLEN] = $urandom;
  endtask

  task automatic settle();
    int sa, sb;
    logic [XLEN-1:0] ea, eb;
    logic [NS-1:0] sv;
    @(negedge clk);
    exp_stall = bus.id_valid && !bus.flush &&
                (must_wait(bus.id_rs1, bus.id_use_rs1) || must_wait(bus.id_rs2, bus.id_use_rs2));
    sa = fwd_src(m[0].rs1, m[0].u1);
    sb = fwd_src(m[0].rs2, m[0].u2);
    ea = (sa == 0) ? bus.ex_rd1 : bus.stage_res[sa*XLEN +: XLEN];
    eb = (sb == 0) ? bus.ex_rd2 : bus.stage_res[sb*XLEN +: XLEN];
    for (int k = 0; k < NS; k++) sv[k] = m[k].v;
    chk("stall", bus.stall, exp_stall);
    chk("fwd_a_sel", bus.fwd_a_sel, sa);
    chk("fwd_b_sel", bus.fwd_b_sel, sb);
    chk("ex_op_a", bus.ex_op_a, ea);
    chk("ex_op_b", bus.ex_op_b, eb);
    chk("slot_valid", bus.slot_valid, sv);
    chk("stall_cnt", bus.stall_cnt, scnt);
    chk("flush_cnt", bus.flush_cnt, fcnt);
    chk("c4_stall", bus4.stall, exp_stall);
    chk("c4_slot_valid", bus4.slot_valid, sv);
    chk("c4_stall_cnt", bus4.stall_cnt, sat4(scnt));
    chk("c4_flush_cnt", bus4.flush_cnt, sat4(fcnt));
  endtask

  task automatic advance();
    if (exp_stall) scnt++;
    if (bus.flush && bus.id_valid) fcnt++;
    for (int k = NS - 1; k >= 1; k--) m[k] = m[k-1];
    if (bus.id_valid && !exp_stall && !bus.flush)
      m[0] = '{v: 1'b1, wen: bus.id_wen, rd: bus.id_rd, lat: int'(bus.id_lat),
               rs1: bus.id_rs1, rs2: bus.id_rs2, u1: bus.id_use_rs1, u2: bus.id_use_rs2};
    else
      m[0] = '{default: 0};
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    settle();
    advance();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      bus.flush = 1'b0;
      rnd_data();
      cycle();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_assert = 0;
    n_fail   = 0;
    model_reset();
    rst_n = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    bus.flush = 1'b0;
    rnd_data();
    #1 rst_n = 1'b0;

    // Reset state with a hazard-looking ID instruction present
    set_id(1, 5, 5, 1, 1, 9, 1, 0);
    @(negedge clk);
    chk("rst_slot_valid", bus.slot_valid, 0);
    chk("rst_stall", bus.stall, 0);
    chk("rst_fwd_a_sel", bus.fwd_a_sel, 0);
    chk("rst_fwd_b_sel", bus.fwd_b_sel, 0);
    chk("rst_ex_op_a", bus.ex_op_a, bus.ex_rd1);
    chk("rst_ex_op_b", bus.ex_op_b, bus.ex_rd2);
    chk("rst_stall_cnt", bus.stall_cnt, 0);
    chk("rst_flush_cnt", bus.flush_cnt, 0);
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // ALU dependency: add x7 then add x8,x7,x6
    rnd_data();
    set_id(1, 1, 2, 1, 1, 7, 1, 0);
    cycle();
    rnd_data();
    set_id(1, 7, 6, 1, 1, 8, 1, 0);
    settle();
    chk("alu_no_stall", bus.stall, 0);
    advance();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    rnd_data();
    bus.stage_res[1*XLEN +: XLEN] = 32'h11;
    settle();
    chk("alu_fwd_a_sel", bus.fwd_a_sel, 1);
    chk("alu_ex_op_a", bus.ex_op_a, 32'h11);
    advance();
    idle(3);

    // Load-use: lw x5 then add x9,x5,x5
    set_id(1, 0, 0, 0, 0, 5, 1, 1);
    cycle();
    set_id(1, 5, 5, 1, 1, 9, 1, 0);
    settle();
    chk("lu_stall", bus.stall, 1);
    advance();
    settle();
    chk("lu_stall_once", bus.stall, 0);
    chk("lu_bubble", bus.slot_valid[0], 0);
    advance();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    rnd_data();
    bus.stage_res[2*XLEN +: XLEN] = 32'hCAFE;
    settle();
    chk("lu_fwd_a_sel", bus.fwd_a_sel, 2);
    chk("lu_fwd_b_sel", bus.fwd_b_sel, 2);
    chk("lu_ex_op_a", bus.ex_op_a, 32'hCAFE);
    chk("lu_ex_op_b", bus.ex_op_b, 32'hCAFE);
    chk("lu_stall_cnt", bus.stall_cnt, 1);
    advance();
    idle(3);

    // x0 never matches
    set_id(1, 0, 0, 0, 0, 0, 1, 1);
    cycle();
    set_id(1, 0, 0, 1, 1, 1, 1, 0);
    settle();
    chk("x0_stall", bus.stall, 0);
    advance();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    rnd_data();
    settle();
    chk("x0_fwd_a_sel", bus.fwd_a_sel, 0);
    chk("x0_ex_op_a", bus.ex_op_a, bus.ex_rd1);
    advance();
    idle(3);

    // Unused rs2 matching a fresh load
    set_id(1, 0, 0, 0, 0, 5, 1, 1);
    cycle();
    set_id(1, 3, 5, 1, 0, 10, 1, 0);
    settle();
    chk("unused_stall", bus.stall, 0);
    advance();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    rnd_data();
    settle();
    chk("unused_fwd_b_sel", bus.fwd_b_sel, 0);
    chk("unused_ex_op_b", bus.ex_op_b, bus.ex_rd2);
    advance();
    idle(3);

    // Shadowing: two writers of x7, nearest one wins
    set_id(1, 0, 0, 0, 0, 7, 1, 0);
    cycle();
    set_id(1, 0, 0, 0, 0, 7, 1, 0);
    cycle();
    set_id(1, 7, 0, 1, 0, 8, 1, 0);
    cycle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    rnd_data();
    bus.stage_res[1*XLEN +: XLEN] = 32'h1111;
    bus.stage_res[2*XLEN +: XLEN] = 32'h2222;
    settle();
    chk("shadow_fwd_a_sel", bus.fwd_a_sel, 1);
    chk("shadow_ex_op_a", bus.ex_op_a, 32'h1111);
    advance();
    idle(3);

    // Young load shadows a ready older ALU writer of x7
    set_id(1, 0, 0, 0, 0, 7, 1, 0);
    cycle();
    set_id(1, 0, 0, 0, 0, 7, 1, 1);
    cycle();
    set_id(1, 7, 0, 1, 0, 8, 1, 0);
    settle();
    chk("shadow_load_stall", bus.stall, 1);
    advance();
    cycle();
    idle(3);

    // Flush wins over a simultaneous load-use stall
    set_id(1, 0, 0, 0, 0, 5, 1, 1);
    cycle();
    set_id(1, 5, 0, 1, 0, 9, 1, 0);
    bus.flush = 1'b1;
    settle();
    chk("flush_stall", bus.stall, 0);
    chk("flush_cnt_before", bus.flush_cnt, 0);
    advance();
    bus.flush = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("flush_cnt_after", bus.flush_cnt, 1);
    chk("flush_bubble", bus.slot_valid[0], 0);
    advance();
    idle(3);

    // Twenty load-use stalls saturate the 4-bit counter
    for (int i = 0; i < 20; i++) begin
      rnd_data();
      set_id(1, 0, 0, 0, 0, 5, 1, 1);
      cycle();
      set_id(1, 5, 5, 1, 1, 9, 1, 0);
      cycle();
      cycle();
    end
    settle();
    chk("c4_stall_cnt_sat", bus4.stall_cnt, 4'hF);
    advance();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rnd_data();
      set_id(($urandom_range(0, 9) != 0), $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7),
             $urandom_range(0, 1), $urandom_range(0, NS - 1));
      bus.flush = ($urandom_range(0, 15) == 0);
      cycle();
    end

    // Asynchronous reset mid-cycle with records in flight
    bus.flush = 1'b0;
    set_id(1, 0, 0, 0, 0, 3, 1, 0);
    cycle();
    set_id(1, 3, 0, 1, 0, 4, 1, 1);
    settle();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_slot_valid", bus.slot_valid, 0);
    chk("arst_c4_slot_valid", bus4.slot_valid, 0);
    chk("arst_stall_cnt", bus.stall_cnt, 0);
    chk("arst_flush_cnt", bus.flush_cnt, 0);
    chk("arst_c4_stall_cnt", bus4.stall_cnt, 0);
    chk("arst_c4_flush_cnt", bus4.flush_cnt, 0);
    chk("arst_stall", bus.stall, 0);
    chk("arst_fwd_a_sel", bus.fwd_a_sel, 0);
    chk("arst_ex_op_a", bus.ex_op_a, bus.ex_rd1);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 40; i++) begin
      rnd_data();
      set_id(1, $urandom_range(0, 7), $urandom_range(0, 7), 1, $urandom_range(0, 1),
             $urandom_range(0, 7), 1, $urandom_range(0, NS - 1));
      bus.flush = ($urandom_range(0, 9) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
